// File: rtl/bsg_axi4_mem_responder.sv
// AXI4 slave backed by a word-addressed on-chip array; one outstanding burst per direction.
// Out-of-range beats and wrong-size bursts are answered with SLVERR instead of touching memory.
module bsg_axi4_mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 6,
  parameter int MEM_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);
  // Handshakes: a transfer happens on a rising aclk edge where valid && ready are both high;
  // valid never waits on ready, and payload is held stable while valid && !ready.

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int AW1    = ADDR_WIDTH + 1;
  localparam logic [2:0]            FULL_SIZE   = 3'(OFF_W);
  localparam logic [ADDR_WIDTH:0]   MEM_BYTES   = AW1'(MEM_WORDS * STRB_W);
  localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES  = ADDR_WIDTH'(STRB_W);
  localparam logic [1:0]            RESP_OKAY   = 2'd0;
  localparam logic [1:0]            RESP_SLVERR = 2'd2;
  localparam logic [1:0]            BURST_FIXED = 2'd0;

  // One extra bit keeps addr < BASE_ADDR visible as a negative offset.
  function automatic logic [ADDR_WIDTH:0] byte_offset(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} - {1'b0, BASE_ADDR};
  endfunction

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] off;
    off = byte_offset(a);
    return !off[ADDR_WIDTH] && (off < MEM_BYTES);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'(byte_offset(a) >> OFF_W);
  endfunction

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  wr_state_t             wr_state;
  rd_state_t             rd_state;
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [7:0]            wr_len, wr_cnt;
  logic [1:0]            wr_burst;
  logic                  wr_size_err, wr_err;
  logic                  w_hs, w_in_range, w_last_beat, w_beat_err, mem_we;

  assign w_hs        = (wr_state == W_DATA) && s_axi_wvalid && s_axi_wready;
  assign w_in_range  = in_range(wr_addr);
  assign w_last_beat = (wr_cnt == wr_len);
  assign w_beat_err  = !w_in_range || (s_axi_wlast != w_last_beat);
  assign mem_we      = w_hs && w_in_range && !wr_size_err;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_state      <= W_IDLE;
      s_axi_awready <= 1'b1;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      s_axi_bid     <= '0;
      wr_addr       <= '0;
      wr_len        <= '0;
      wr_cnt        <= '0;
      wr_burst      <= '0;
      wr_size_err   <= 1'b0;
      wr_err        <= 1'b0;
    end else begin
      case (wr_state)
        W_IDLE: if (s_axi_awvalid && s_axi_awready) begin
          wr_addr       <= s_axi_awaddr;
          wr_len        <= s_axi_awlen;
          wr_burst      <= s_axi_awburst;
          wr_size_err   <= (s_axi_awsize != FULL_SIZE);
          wr_err        <= (s_axi_awsize != FULL_SIZE);
          wr_cnt        <= '0;
          s_axi_bid     <= s_axi_awid;
          s_axi_awready <= 1'b0;
          s_axi_wready  <= 1'b1;
          wr_state      <= W_DATA;
        end
        W_DATA: if (w_hs) begin
          wr_cnt <= wr_cnt + 8'd1;
          if (wr_burst != BURST_FIXED) wr_addr <= wr_addr + BEAT_BYTES;
          if (w_last_beat) begin
            s_axi_wready <= 1'b0;
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= (wr_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
            wr_state     <= W_RESP;
          end else if (w_beat_err) begin
            wr_err <= 1'b1;
          end
        end
        W_RESP: if (s_axi_bready) begin
          s_axi_bvalid  <= 1'b0;
          s_axi_awready <= 1'b1;
          wr_state      <= W_IDLE;
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Contents survive reset; byte lanes follow wstrb.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) mem[word_idx(wr_addr)][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  logic [ADDR_WIDTH-1:0] rd_addr, fetch_addr;
  logic [7:0]            rd_len, rd_cnt;
  logic [1:0]            rd_burst;
  logic                  rd_size_err, fetch_size_err, fetch_ok;
  logic [DATA_WIDTH-1:0] fetch_data;

  // Address of the beat that the next register update will present.
  always_comb begin
    fetch_addr     = s_axi_araddr;
    fetch_size_err = (s_axi_arsize != FULL_SIZE);
    if (rd_state == R_DATA) begin
      fetch_addr     = (rd_burst == BURST_FIXED) ? rd_addr : rd_addr + BEAT_BYTES;
      fetch_size_err = rd_size_err;
    end
    fetch_ok   = in_range(fetch_addr) && !fetch_size_err;
    fetch_data = fetch_ok ? mem[word_idx(fetch_addr)] : '0;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rd_state      <= R_IDLE;
      s_axi_arready <= 1'b1;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rid     <= '0;
      s_axi_rdata   <= '0;
      rd_addr       <= '0;
      rd_len        <= '0;
      rd_cnt        <= '0;
      rd_burst      <= '0;
      rd_size_err   <= 1'b0;
    end else begin
      case (rd_state)
        R_IDLE: if (s_axi_arvalid && s_axi_arready) begin
          rd_addr       <= fetch_addr;
          rd_len        <= s_axi_arlen;
          rd_cnt        <= '0;
          rd_burst      <= s_axi_arburst;
          rd_size_err   <= fetch_size_err;
          s_axi_rid     <= s_axi_arid;
          s_axi_rdata   <= fetch_data;
          s_axi_rresp   <= fetch_ok ? RESP_OKAY : RESP_SLVERR;
          s_axi_rlast   <= (s_axi_arlen == 8'd0);
          s_axi_rvalid  <= 1'b1;
          s_axi_arready <= 1'b0;
          rd_state      <= R_DATA;
        end
        R_DATA: if (s_axi_rready) begin
          if (s_axi_rlast) begin
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_arready <= 1'b1;
            rd_state      <= R_IDLE;
          end else begin
            rd_addr     <= fetch_addr;
            rd_cnt      <= rd_cnt + 8'd1;
            s_axi_rdata <= fetch_data;
            s_axi_rresp <= fetch_ok ? RESP_OKAY : RESP_SLVERR;
            s_axi_rlast <= ((rd_cnt + 8'd1) == rd_len);
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bsg_axi4_mem_responder.sv
// Directed bench for bsg_axi4_mem_responder: a word-level memory model predicts every R and B
// beat, and a per-test set of literal expectations pins the model itself.
module tb_bsg_axi4_mem_responder;
  localparam int LIM = 200;
  localparam logic [31:0] MEM_BYTES = 32'd4096;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] s_axi_awaddr, s_axi_araddr, s_axi_wdata, s_axi_rdata;
  logic [5:0]  s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
  logic [7:0]  s_axi_awlen, s_axi_arlen;
  logic [2:0]  s_axi_awsize, s_axi_arsize;
  logic [1:0]  s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;

  bsg_axi4_mem_responder dut (
    .aclk(aclk), .areset(areset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awid(s_axi_awid), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arid(s_axi_arid), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rid(s_axi_rid), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  // ---------------- clock / reset ----------------
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- model + scoreboard ----------------
  logic [31:0] mm [int];              // word index -> known contents
  logic [41:0] exp_r_q [$];           // {chk_data, last, resp, id, data}
  logic [7:0]  exp_b_q [$];           // {id, resp}
  int          aw_cyc_q [$], b_cyc_q [$];
  int          cyc = 0;
  bit          ar_lat = 0;
  logic [31:0] m_aw_addr;
  logic [7:0]  m_aw_len;
  logic [2:0]  m_aw_size;
  logic [1:0]  m_aw_burst;
  logic [5:0]  m_aw_id;
  int          m_w_beat;
  bit          m_err;

  always @(negedge aclk) begin
    logic [41:0] e;
    logic [31:0] a;
    bit          last;
    cyc++;
    if (areset) begin
      exp_r_q.delete();
      exp_b_q.delete();
      ar_lat = 0;
    end else begin
      if (ar_lat) begin
        check("r_latency", s_axi_rvalid, 1);
        ar_lat = 0;
      end
      if (s_axi_rvalid) begin
        if (exp_r_q.size() == 0) check("r_unexpected", 1, 0);
        else begin
          e = exp_r_q[0];
          if (e[41]) check("r_data", s_axi_rdata, e[31:0]);
          check("r_last", s_axi_rlast, e[40]);
          check("r_resp", s_axi_rresp, e[39:38]);
          check("r_id", s_axi_rid, e[37:32]);
          if (s_axi_rready) void'(exp_r_q.pop_front());
        end
      end
      if (s_axi_bvalid) begin
        if (exp_b_q.size() == 0) check("b_unexpected", 1, 0);
        else begin
          check("b_id", s_axi_bid, exp_b_q[0][7:2]);
          check("b_resp", s_axi_bresp, exp_b_q[0][1:0]);
          if (s_axi_bready) begin
            void'(exp_b_q.pop_front());
            b_cyc_q.push_back(cyc);
          end
        end
      end
      // Read expectations are taken before this cycle's write lands: reads see pre-write data.
      if (s_axi_arvalid && s_axi_arready) begin
        for (int i = 0; i <= int'(s_axi_arlen); i++) begin
          a = (s_axi_arburst == 2'd0) ? s_axi_araddr : s_axi_araddr + 32'(4 * i);
          last = (i == int'(s_axi_arlen));
          if (a >= MEM_BYTES || s_axi_arsize != 3'd2) e = {1'b1, last, 2'd2, s_axi_arid, 32'd0};
          else if (mm.exists(int'(a >> 2))) e = {1'b1, last, 2'd0, s_axi_arid, mm[int'(a >> 2)]};
          else e = {1'b0, last, 2'd0, s_axi_arid, 32'd0};
          exp_r_q.push_back(e);
        end
        ar_lat = 1;
      end
      if (s_axi_awvalid && s_axi_awready) begin
        m_aw_addr = s_axi_awaddr; m_aw_len = s_axi_awlen; m_aw_size = s_axi_awsize;
        m_aw_burst = s_axi_awburst; m_aw_id = s_axi_awid;
        m_w_beat = 0; m_err = (s_axi_awsize != 3'd2);
        aw_cyc_q.push_back(cyc);
      end
      if (s_axi_wvalid && s_axi_wready) begin
        a = (m_aw_burst == 2'd0) ? m_aw_addr : m_aw_addr + 32'(4 * m_w_beat);
        last = (m_w_beat == int'(m_aw_len));
        if (a >= MEM_BYTES) m_err = 1;
        else if (m_aw_size == 3'd2) begin
          if (mm.exists(int'(a >> 2))) begin
            for (int b = 0; b < 4; b++)
              if (s_axi_wstrb[b]) mm[int'(a >> 2)][8*b +: 8] = s_axi_wdata[8*b +: 8];
          end else if (s_axi_wstrb == 4'hF) mm[int'(a >> 2)] = s_axi_wdata;
        end
        if (s_axi_wlast != last) m_err = 1;
        if (last) exp_b_q.push_back({m_aw_id, m_err ? 2'd2 : 2'd0});
        m_w_beat++;
      end
    end
  end

  // ---------------- driver tasks (entered and left at posedge + 1) ----------------
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] got_d [16];
  logic        got_l [16];
  logic [1:0]  got_r [16];

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [5:0] id, input bit bad_last,
                           input int b_delay, output logic [1:0] resp, output logic [5:0] bid);
    int t;
    resp = 2'bxx; bid = 'x;
    s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awsize = size;
    s_axi_awburst = burst; s_axi_awid = id; s_axi_awvalid = 1;
    t = 0; @(negedge aclk);
    while (!s_axi_awready && t < LIM) begin t++; @(negedge aclk); end
    if (t >= LIM) begin check("aw_timeout", 1, 0); s_axi_awvalid = 0; return; end
    @(posedge aclk); #1 s_axi_awvalid = 0;
    for (int i = 0; i <= int'(len); i++) begin
      s_axi_wdata = wd[i]; s_axi_wstrb = ws[i];
      s_axi_wlast = (i == int'(len)) && !bad_last; s_axi_wvalid = 1;
      t = 0; @(negedge aclk);
      while (!s_axi_wready && t < LIM) begin t++; @(negedge aclk); end
      if (t >= LIM) begin check("w_timeout", 1, 0); s_axi_wvalid = 0; return; end
      @(posedge aclk); #1;
    end
    s_axi_wvalid = 0; s_axi_wlast = 0;
    t = 0; @(negedge aclk);
    while (!s_axi_bvalid && t < LIM) begin t++; @(negedge aclk); end
    if (t >= LIM) begin check("b_timeout", 1, 0); return; end
    resp = s_axi_bresp; bid = s_axi_bid;
    @(posedge aclk); #1;
    repeat (b_delay) begin @(posedge aclk); #1; end
    s_axi_bready = 1;
    @(posedge aclk); #1 s_axi_bready = 0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [5:0] id,
                          input logic [1:0] burst, input bit stall);
    int t, n;
    s_axi_araddr = addr; s_axi_arlen = len; s_axi_arsize = 3'd2;
    s_axi_arburst = burst; s_axi_arid = id; s_axi_arvalid = 1;
    t = 0; @(negedge aclk);
    while (!s_axi_arready && t < LIM) begin t++; @(negedge aclk); end
    if (t >= LIM) begin check("ar_timeout", 1, 0); s_axi_arvalid = 0; return; end
    @(posedge aclk); #1 s_axi_arvalid = 0;
    n = 0; t = 0;
    while (n <= int'(len) && t < LIM) begin
      s_axi_rready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge aclk);
      if (s_axi_rvalid && s_axi_rready) begin
        got_d[n] = s_axi_rdata; got_l[n] = s_axi_rlast; got_r[n] = s_axi_rresp; n++;
      end
      t++;
      @(posedge aclk); #1;
    end
    s_axi_rready = 0;
    if (n <= int'(len)) check("r_timeout", 1, 0);
  endtask

  task automatic fill(input logic [31:0] first, input logic [31:0] step, input logic [3:0] strb);
    for (int i = 0; i < 16; i++) begin
      wd[i] = first + step * 32'(i);
      ws[i] = strb;
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic [1:0] resp;
    logic [5:0] bid;
    int t, n;
    s_axi_awaddr = 0; s_axi_awid = 0; s_axi_awlen = 0; s_axi_awsize = 0; s_axi_awburst = 0;
    s_axi_awvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wlast = 0; s_axi_wvalid = 0;
    s_axi_bready = 0; s_axi_araddr = 0; s_axi_arid = 0; s_axi_arlen = 0; s_axi_arsize = 0;
    s_axi_arburst = 0; s_axi_arvalid = 0; s_axi_rready = 0;
    areset = 0;
    #1 areset = 1;
    #2;
    check("rst_awready", s_axi_awready, 1);
    check("rst_arready", s_axi_arready, 1);
    check("rst_wready", s_axi_wready, 0);
    check("rst_bvalid", s_axi_bvalid, 0);
    check("rst_rvalid", s_axi_rvalid, 0);
    check("rst_rlast", s_axi_rlast, 0);
    check("rst_bresp", s_axi_bresp, 0);
    check("rst_rresp", s_axi_rresp, 0);
    check("rst_bid", s_axi_bid, 0);
    check("rst_rid", s_axi_rid, 0);
    check("rst_rdata", s_axi_rdata, 0);
    repeat (2) @(posedge aclk);
    #1 areset = 0;

    // single write then read
    fill(32'hDEADBEEF, 0, 4'hF);
    axi_write(32'h10, 0, 3'd2, 2'd1, 6'd5, 0, 0, resp, bid);
    check("single_bresp", resp, 0);
    check("single_bid", bid, 6'd5);
    axi_read(32'h10, 0, 6'd9, 2'd1, 0);
    check("single_rdata", got_d[0], 32'hDEADBEEF);
    check("single_rlast", got_l[0], 1);
    check("single_rresp", got_r[0], 0);

    // INCR burst of 8, read back under random rready stalls
    fill(0, 1, 4'hF);
    axi_write(32'h100, 7, 3'd2, 2'd1, 6'd1, 0, 0, resp, bid);
    check("incr_bresp", resp, 0);
    axi_read(32'h100, 7, 6'd2, 2'd1, 1);
    for (int i = 0; i < 8; i++) begin
      check("incr_rdata", got_d[i], 32'(i));
      check("incr_rlast", got_l[i], (i == 7));
    end

    // FIXED burst lands every beat on one word; then a partial-strobe merge
    fill(1, 1, 4'hF);
    axi_write(32'h40, 3, 3'd2, 2'd0, 6'd3, 0, 0, resp, bid);
    check("fixed_bresp", resp, 0);
    axi_read(32'h40, 0, 6'd3, 2'd1, 0);
    check("fixed_rdata", got_d[0], 32'd4);
    fill(32'hFFFFFFFF, 0, 4'hF);
    axi_write(32'h44, 0, 3'd2, 2'd1, 6'd3, 0, 0, resp, bid);
    fill(32'hAAAA5555, 0, 4'h3);
    axi_write(32'h44, 0, 3'd2, 2'd1, 6'd3, 0, 0, resp, bid);
    axi_read(32'h44, 0, 6'd3, 2'd1, 0);
    check("strobe_rdata", got_d[0], 32'hFFFF5555);

    // out-of-range read/write; the aliased word 0 must stay intact
    fill(32'hCAFEF00D, 0, 4'hF);
    axi_write(32'h0, 0, 3'd2, 2'd1, 6'd4, 0, 0, resp, bid);
    axi_read(32'h1000, 0, 6'd6, 2'd1, 0);
    check("oor_rdata", got_d[0], 0);
    check("oor_rresp", got_r[0], 2);
    fill(32'h12345678, 0, 4'hF);
    axi_write(32'h1000, 0, 3'd2, 2'd1, 6'd7, 0, 0, resp, bid);
    check("oor_bresp", resp, 2);
    axi_read(32'h0, 0, 6'd6, 2'd1, 0);
    check("oor_unchanged", got_d[0], 32'hCAFEF00D);

    // wrong size: burst rejected, memory untouched
    fill(32'h0BADF00D, 0, 4'hF);
    axi_write(32'h80, 0, 3'd2, 2'd1, 6'd8, 0, 0, resp, bid);
    fill(32'h11, 32'h11, 4'hF);
    axi_write(32'h80, 1, 3'd1, 2'd1, 6'd8, 0, 0, resp, bid);
    check("size_bresp", resp, 2);
    axi_read(32'h80, 0, 6'd8, 2'd1, 0);
    check("size_unchanged", got_d[0], 32'h0BADF00D);

    // missing wlast: SLVERR but data still written
    fill(32'hA0, 1, 4'hF);
    axi_write(32'h88, 1, 3'd2, 2'd1, 6'd9, 1, 0, resp, bid);
    check("wlast_bresp", resp, 2);
    axi_read(32'h88, 1, 6'd9, 2'd1, 0);
    check("wlast_beat0", got_d[0], 32'hA0);
    check("wlast_beat1", got_d[1], 32'hA1);

    // read and write hit word 0x200 in the same cycle; a second AW waits out the WRESP
    fill(32'h11112222, 0, 4'hF);
    axi_write(32'h200, 0, 3'd2, 2'd1, 6'd10, 0, 0, resp, bid);
    aw_cyc_q.delete(); b_cyc_q.delete();
    fill(32'h33334444, 0, 4'hF);
    fork
      begin
        logic [1:0] r1; logic [5:0] i1;
        axi_write(32'h200, 0, 3'd2, 2'd1, 6'd11, 0, 3, r1, i1);
        check("conc_bresp", r1, 0);
      end
      begin
        @(posedge aclk); #1;
        axi_read(32'h200, 0, 6'd12, 2'd1, 0);
        check("conc_old_data", got_d[0], 32'h11112222);
      end
      begin
        logic [1:0] r2; logic [5:0] i2;
        t = 0; @(negedge aclk);
        while (!s_axi_bvalid && t < LIM) begin t++; @(negedge aclk); end
        @(posedge aclk); #1;
        axi_write(32'h204, 0, 3'd2, 2'd1, 6'd13, 0, 0, r2, i2);
        check("conc_second_bid", i2, 6'd13);
      end
    join
    if (aw_cyc_q.size() == 2 && b_cyc_q.size() == 2)
      check("conc_aw_after_b", aw_cyc_q[1] - b_cyc_q[0], 1);
    else check("conc_hs_count", aw_cyc_q.size() * 10 + b_cyc_q.size(), 22);
    axi_read(32'h200, 1, 6'd14, 2'd1, 0);
    check("conc_new_data", got_d[0], 32'h33334444);
    check("conc_second_data", got_d[1], 32'h33334444);

    // reset during beat 3 of an 8-beat read
    s_axi_araddr = 32'h100; s_axi_arlen = 7; s_axi_arsize = 3'd2;
    s_axi_arburst = 2'd1; s_axi_arid = 6'd15; s_axi_arvalid = 1;
    t = 0; @(negedge aclk);
    while (!s_axi_arready && t < LIM) begin t++; @(negedge aclk); end
    @(posedge aclk); #1 s_axi_arvalid = 0; s_axi_rready = 1;
    n = 0; t = 0;
    while (n < 3 && t < LIM) begin
      @(negedge aclk);
      if (s_axi_rvalid && s_axi_rready) n++;
      t++;
    end
    check("rst_mid_beats", n, 3);
    @(posedge aclk); #2 areset = 1;
    #1;
    check("rst_mid_rvalid", s_axi_rvalid, 0);
    check("rst_mid_rlast", s_axi_rlast, 0);
    s_axi_rready = 0;
    repeat (2) @(posedge aclk);
    #1 areset = 0;
    @(negedge aclk);
    check("rst_mid_arready", s_axi_arready, 1);
    check("rst_mid_awready", s_axi_awready, 1);
    @(posedge aclk); #1;
    axi_read(32'h100, 7, 6'd16, 2'd1, 0);
    check("post_rst_beat0", got_d[0], 32'd0);
    check("post_rst_beat7", got_d[7], 32'd7);
    check("post_rst_last", got_l[7], 1);

    repeat (3) @(posedge aclk);
    check("exp_r_drained", exp_r_q.size(), 0);
    check("exp_b_drained", exp_b_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bsg_axi4_mem_responder.md
Name: bsg_axi4_mem_responder

Overview:
- AXI4 full-protocol slave; the responder end of the DRAM-side master port that the top-level shell exposes.
- Backs a burst-capable master with a word-addressed on-chip memory array, so the dram-example design can be cosimulated and run on FPGA without the PS DDR controller.
- Independent write path (AW/W/B) and read path (AR/R); one outstanding transaction per path.

Parameters:
- DATA_WIDTH, 32, AXI data width in bits; power of 2, at least 32.
- ADDR_WIDTH, 32, AXI address width.
- ID_WIDTH, 6, AXI ID width.
- MEM_WORDS, 1024, depth of the backing array in DATA_WIDTH words; power of 2.
- BASE_ADDR, 0, byte address that maps to word 0.

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous, active-high reset
- s_axi_awaddr/awid/awlen/awsize/awburst  in  ADDR_WIDTH/ID_WIDTH/8/3/2  write address
- s_axi_awvalid  in  1 ; s_axi_awready  out  1
- s_axi_wdata/wstrb/wlast  in  DATA_WIDTH/DATA_WIDTH/8/1  write data
- s_axi_wvalid  in  1 ; s_axi_wready  out  1
- s_axi_bid/bresp  out  ID_WIDTH/2  write response ; s_axi_bvalid  out  1 ; s_axi_bready  in  1
- s_axi_araddr/arid/arlen/arsize/arburst  in  ADDR_WIDTH/ID_WIDTH/8/3/2  read address
- s_axi_arvalid  in  1 ; s_axi_arready  out  1
- s_axi_rdata/rid/rresp/rlast  out  DATA_WIDTH/ID_WIDTH/2/1  read data ; s_axi_rvalid  out  1 ; s_axi_rready  in  1

Behaviour:
- Reset (async assert, sync release): both FSMs go to IDLE.
  - awready=1, arready=1; wready, bvalid, rvalid, rlast = 0; bresp/rresp/bid/rid/rdata = 0.
  - Memory contents are not reset.
- Write FSM: IDLE -> WDATA -> WRESP -> IDLE.
  - IDLE: awready=1. On AW handshake, latch id, addr, len, size, burst; beat count = 0; err = 0.
  - WDATA: wready=1. On each W handshake, write the word at the current address, byte-enabled by wstrb, in the same cycle.
  - Address update per beat: INCR (and WRAP, treated as INCR) adds DATA_WIDTH/8; FIXED holds.
  - Leave WDATA after awlen+1 beats, independent of wlast.
  - WRESP: bvalid=1, bid = latched id. Hold until bready, then go to IDLE. awready is reasserted the cycle after the B handshake.
- Read FSM: IDLE -> RDATA -> IDLE.
  - IDLE: arready=1. AR handshake in cycle N gives rvalid=1 in cycle N+1 with beat 0 data registered.
  - rdata, rresp, rlast and rid stay stable while rvalid && !rready.
  - On an R handshake the next beat is presented the following cycle, with no bubble while rready stays high.
  - rlast=1 only on beat arlen. The R handshake on the last beat returns to IDLE; arready=1 in the next cycle.
- Word index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8), truncated to log2(MEM_WORDS) bits.
- Error conditions:
  - Address out of range (addr < BASE_ADDR or >= BASE_ADDR + MEM_WORDS*DATA_WIDTH/8), evaluated per beat: write beat dropped; read beat returns rdata=0 with rresp=SLVERR(2).
  - size != log2(DATA_WIDTH/8): whole burst flagged SLVERR; writes are dropped.
  - wlast mismatch (wlast on a non-final beat, or missing on the final beat): sets err; data is still written.
  - bresp = SLVERR if err was set on any beat, else OKAY(0).
- Simultaneous events:
  - A read and a write to the same word in the same cycle: the read captures pre-write data.
  - Back-to-back AW arriving during WDATA/WRESP is stalled by awready=0 and never dropped.
- Reset mid-burst: all valids drop asynchronously and FSMs return to IDLE. Partially written words stay written.

Test Plan:
- Single write: awaddr=0x10, awlen=0, size=2, wdata=0xDEADBEEF, wstrb=0xF. Then read 0x10 -> bresp=0, bid=awid; rdata=0xDEADBEEF, rlast=1, rresp=0; rvalid exactly 1 cycle after the AR handshake.
- INCR burst: write awlen=7 at 0x100 with data 0..7, then read arlen=7 -> 8 beats 0..7 in order, rlast only on beat 7. Random rready stalls must keep rdata stable.
- FIXED burst of 4 writes to 0x40 (data 1,2,3,4), then a single read -> 4. Partial strobe 0x3 with data 0xAAAA5555 over 0xFFFFFFFF -> 0xFFFF5555.
- Out-of-range: read at BASE_ADDR + MEM_WORDS*4 -> rdata=0, rresp=2. Write there -> bresp=2, memory unchanged. Size=1 burst -> SLVERR.
- Concurrency: simultaneous AW/AR to the same word, plus a second AW issued during WRESP -> read returns old data; second AW accepted only after the B handshake.
- Assert areset during beat 3 of an 8-beat read -> rvalid=0 immediately, arready=1 after release, and the next read completes normally.
